mvu_pe_simd_xnor_acc: RTL and testbench
=======================================

// Module: mvu_pe_simd_xnor_acc
// PURPOSE
//  SIMD-wide binary (1-bit x 1-bit) processing-element datapath for the MVAU stream.
//  Each beat: XNORs SIMD activation bits against SIMD weight bits, popcounts the result, and
//  accumulates over SF beats (one synapse fold) to produce one dot-product output per fold.
//  Pipelined (XNOR reg -> popcount reg -> accumulator); optional bipolar (+1/-1) output
//  mapping. Sits between the weight/activation slicers and the PE output register.
// PARAMETERS
//  SIMD     8   bits per beat (XNOR lanes); >= 1
//  SF       4   beats accumulated per output (synapse fold); >= 1
//  TDstI    16  output word length; elaboration error if clog2(SIMD*SF+1)+BIPOLAR > TDstI
//  BIPOLAR  0   0: out = unsigned match count; 1: out = signed 2*count - SIMD*SF
// PORTS
//  aclk     in   1      clock, all logic on rising edge
//  areset   in   1      synchronous reset, active-high
//  in_v     in   1      input beat valid
//  in_act   in   SIMD   activation bits (lane i = bit i)
//  in_wgt   in   SIMD   weight bits (lane i = bit i)
//  out_v    out  1      one-cycle pulse: out carries a completed fold result
//  out      out  TDstI  fold result (unsigned or two's-complement per BIPOLAR)
// BEHAVIOUR
//  - Reset (areset=1 at edge): all stage valids=0, fold counter=0, accumulator=0, out=0,
//    out_v=0. Inputs ignored while areset=1. Reset mid-fold discards the partial sum; no
//    output is produced for it. First in_v beat after reset starts fold beat 0.
//  - No backpressure: every in_v=1 beat is consumed. in_v=0 cycles are bubbles; they
//    propagate as invalid stages and do not advance the fold counter or accumulator.
//  - S1 (cycle t+1): xnr <= ~(in_act ^ in_wgt); v1 <= in_v.
//  - S2 (cycle t+2): pop <= popcount(xnr), width clog2(SIMD+1); v2 <= v1.
//  - S3 (cycle t+3), when v2=1:
//      acc_next = (cnt==0) ? pop : acc + pop   (width clog2(SIMD*SF+1), never overflows)
//      acc <= acc_next
//      if cnt==SF-1: cnt<=0, out_v<=1, out<=map(acc_next) else cnt<=cnt+1, out_v<=0.
//    When v2=0: acc, cnt, out hold; out_v<=0.
//  - map: BIPOLAR=0 -> zero-extend to TDstI; BIPOLAR=1 -> 2*acc_next - SIMD*SF,
//    sign-extended to TDstI (range -SIMD*SF..+SIMD*SF).
//  - Latency: out_v=1 exactly 3 cycles after the edge sampling the SF-th valid beat.
//  - Throughput: continuous in_v gives one out_v pulse every SF cycles; SF=1 gives one per
//    cycle. out holds its last value between pulses.
//  - fold counter width max(1,clog2(SF)); wraps SF-1 -> 0 only on the fold-completing beat.
// TESTING (SIMD=8, SF=4, TDstI=16 unless stated)
//  1. in_act=8'hFF, in_wgt=8'hFF, 4 consecutive valid beats -> out=16'd32, out_v high 1 cycle,
//     3 cycles after 4th beat; out stays 32 afterwards with out_v=0.
//  2. in_act=8'hFF, in_wgt=8'h00 x4 -> out=0; same with BIPOLAR=1 -> out=16'hFFE0 (-32);
//     in_act=in_wgt=8'hAA x4 with BIPOLAR=1 -> out=16'd32.
//  3. Valid beats at cycles 0,2,5,6 (bubbles between), each act=8'h0F wgt=8'hFF -> single
//     out_v at cycle 9, out=16; no out_v earlier.
//  4. 2 valid beats (act=wgt=8'hFF), assert areset 1 cycle, then 4 beats act=8'hF0 wgt=8'hFF
//     -> no output for the aborted fold; next out=16; out=0/out_v=0 during and after reset.
//  5. SF=1, 200 cycles random act/wgt/in_v -> every valid beat yields out_v 3 cycles later,
//     out = popcount(~(act^wgt)); scoreboard against reference model.
//  6. 12 back-to-back beats alternating act=8'h55/8'hAA, wgt=8'h55 -> 3 outputs at
//     cycles 6,10,14 (first beat at cycle 0), each out=16.

Source files
------------

// File: rtl/mvu_pe_simd_xnor_acc.sv
// Binary SIMD processing element: lane-wise XNOR, popcount, and accumulation over one synapse fold.
// Three register stages (xnor -> popcount -> accumulator/output) with optional bipolar output mapping.
module mvu_pe_simd_xnor_acc #(
   parameter int SIMD    = 8,
   parameter int SF      = 4,
   parameter int TDstI   = 16,
   parameter int BIPOLAR = 0
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             in_v,
   input  logic [SIMD-1:0]  in_act,
   input  logic [SIMD-1:0]  in_wgt,
   output logic             out_v,
   output logic [TDstI-1:0] out
);

   localparam int POP_W = $clog2(SIMD + 1);
   localparam int ACC_W = $clog2(SIMD * SF + 1);
   localparam int CNT_W = (SF > 1) ? $clog2(SF) : 1;
   localparam int BP_W  = (BIPOLAR != 0) ? 1 : 0;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SF - 1);
   localparam logic [TDstI-1:0] TOTAL_T  = TDstI'(SIMD * SF);

   generate
      if (ACC_W + BP_W > TDstI) begin : g_width_err
         $error("mvu_pe_simd_xnor_acc: TDstI too narrow for SIMD*SF (+ sign when BIPOLAR)");
      end
   endgenerate

   function automatic logic [POP_W-1:0] popcount(input logic [SIMD-1:0] vec);
      logic [POP_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < SIMD; i++) begin
         cnt = cnt + POP_W'(vec[i]);
      end
      return cnt;
   endfunction

   // Bipolar: each match is +1 and each mismatch -1, so the sum is 2*matches - SIMD*SF.
   function automatic logic [TDstI-1:0] map_out(input logic [ACC_W-1:0] acc);
      logic [TDstI-1:0] ext;
      ext = TDstI'(acc);
      if (BP_W != 0) begin
         return (ext << 1) - TOTAL_T;
      end else begin
         return ext;
      end
   endfunction

   logic [SIMD-1:0]  xnr_q;
   logic             v1_q;
   logic [POP_W-1:0] pop_q;
   logic             v2_q;
   logic [ACC_W-1:0] acc_q, acc_d, acc_sum_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TDstI-1:0] out_q, out_d;
   logic             out_v_q, out_v_d;

   always_ff @(posedge aclk) begin
      if (areset) begin
         xnr_q <= '0;
         v1_q  <= 1'b0;
         pop_q <= '0;
         v2_q  <= 1'b0;
      end else begin
         xnr_q <= ~(in_act ^ in_wgt);
         v1_q  <= in_v;
         pop_q <= popcount(xnr_q);
         v2_q  <= v1_q;
      end
   end

   // The first beat of a fold restarts the sum instead of adding to the previous fold's total.
   always_comb begin
      acc_sum_s = (cnt_q == '0) ? ACC_W'(pop_q) : (acc_q + ACC_W'(pop_q));
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      out_v_d   = 1'b0;
      if (v2_q) begin
         acc_d = acc_sum_s;
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            out_v_d = 1'b1;
            out_d   = map_out(acc_sum_s);
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else begin
         acc_d = acc_q;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         out_v_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         out_v_q <= out_v_d;
      end
   end

   assign out   = out_q;
   assign out_v = out_v_q;

endmodule

// File: tb/tb_mvu_pe_simd_xnor_acc.sv
// Directed bench for mvu_pe_simd_xnor_acc: default, bipolar and SF=1 instances share one stimulus bus.
module tb_mvu_pe_simd_xnor_acc;

   logic        aclk = 1'b0;
   logic        areset;
   logic        in_v;
   logic [7:0]  in_act, in_wgt;
   logic        ov_a, ov_b, ov_c;
   logic [15:0] o_a, o_b, o_c;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 aclk = ~aclk;

   mvu_pe_simd_xnor_acc #(.SIMD(8), .SF(4), .TDstI(16), .BIPOLAR(0)) dut_a (
      .aclk(aclk), .areset(areset), .in_v(in_v), .in_act(in_act), .in_wgt(in_wgt),
      .out_v(ov_a), .out(o_a));

   mvu_pe_simd_xnor_acc #(.SIMD(8), .SF(4), .TDstI(16), .BIPOLAR(1)) dut_b (
      .aclk(aclk), .areset(areset), .in_v(in_v), .in_act(in_act), .in_wgt(in_wgt),
      .out_v(ov_b), .out(o_b));

   mvu_pe_simd_xnor_acc #(.SIMD(8), .SF(1), .TDstI(16), .BIPOLAR(0)) dut_c (
      .aclk(aclk), .areset(areset), .in_v(in_v), .in_act(in_act), .in_wgt(in_wgt),
      .out_v(ov_c), .out(o_c));

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] w);
      in_v   = v;
      in_act = a;
      in_wgt = w;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      drive(1'b0, 8'h00, 8'h00);
      step();
      step();
      areset = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      drive(1'b1, 8'hFF, 8'hFF);
      step();
      step();
      n_checks++; if (ov_a !== 1'b0 || o_a !== 16'd0) $display("FAIL reset_a out_v=%b out=%h exp 0/0000", ov_a, o_a); else n_pass++;
      n_checks++; if (ov_b !== 1'b0 || o_b !== 16'd0) $display("FAIL reset_b out_v=%b out=%h exp 0/0000", ov_b, o_b); else n_pass++;
      n_checks++; if (ov_c !== 1'b0 || o_c !== 16'd0) $display("FAIL reset_c out_v=%b out=%h exp 0/0000", ov_c, o_c); else n_pass++;
      areset = 1'b0;
      drive(1'b0, 8'hFF, 8'hFF);
      for (int c = 0; c < 5; c++) begin
         step();
         n_checks++; if (ov_a !== 1'b0 || ov_c !== 1'b0) $display("FAIL reset_idle c=%0d out_v a=%b c=%b exp 0", c, ov_a, ov_c); else n_pass++;
      end
   endtask

   task automatic test_all_match();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         n_checks++; if (ov_a !== (c == 6)) $display("FAIL match_outv c=%0d got %b exp %b", c, ov_a, (c == 6)); else n_pass++;
         if (c < 6) begin
            n_checks++; if (o_a !== 16'd0) $display("FAIL match_early c=%0d out=%0d exp 0", c, o_a); else n_pass++;
         end
         if (c >= 6) begin
            n_checks++; if (o_a !== 16'd32) $display("FAIL match_out c=%0d out=%0d exp 32", c, o_a); else n_pass++;
            n_checks++; if (o_b !== 16'd32) $display("FAIL match_bp c=%0d out=%h exp 0020", c, o_b); else n_pass++;
         end
         if (c >= 3 && c <= 6) begin
            n_checks++; if (ov_c !== 1'b1 || o_c !== 16'd8) $display("FAIL match_sf1 c=%0d out_v=%b out=%0d exp 1/8", c, ov_c, o_c); else n_pass++;
         end
         drive(c < 4, 8'hFF, 8'hFF);
         step();
      end
   endtask

   task automatic test_bipolar();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         n_checks++; if (ov_b !== (c == 6 || c == 10)) $display("FAIL bp_outv c=%0d got %b exp %b", c, ov_b, (c == 6 || c == 10)); else n_pass++;
         if (c == 6) begin
            n_checks++; if (o_a !== 16'd0) $display("FAIL bp_zero_u out=%h exp 0000", o_a); else n_pass++;
            n_checks++; if (o_b !== 16'hFFE0) $display("FAIL bp_neg out=%h exp ffe0", o_b); else n_pass++;
         end
         if (c == 10) begin
            n_checks++; if (o_a !== 16'd32) $display("FAIL bp_aa_u out=%h exp 0020", o_a); else n_pass++;
            n_checks++; if (o_b !== 16'd32) $display("FAIL bp_aa out=%h exp 0020", o_b); else n_pass++;
         end
         if (c == 5) begin
            n_checks++; if (ov_c !== 1'b1 || o_c !== 16'd0) $display("FAIL bp_sf1_zero out_v=%b out=%0d exp 1/0", ov_c, o_c); else n_pass++;
         end
         if (c == 9) begin
            n_checks++; if (ov_c !== 1'b1 || o_c !== 16'd8) $display("FAIL bp_sf1_aa out_v=%b out=%0d exp 1/8", ov_c, o_c); else n_pass++;
         end
         if (c < 4) drive(1'b1, 8'hFF, 8'h00);
         else if (c < 8) drive(1'b1, 8'hAA, 8'hAA);
         else drive(1'b0, 8'h00, 8'h00);
         step();
      end
   endtask

   task automatic test_bubbles();
      logic beat;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         n_checks++; if (ov_a !== (c == 9)) $display("FAIL bub_outv c=%0d got %b exp %b", c, ov_a, (c == 9)); else n_pass++;
         if (c == 9) begin
            n_checks++; if (o_a !== 16'd16) $display("FAIL bub_out out=%0d exp 16", o_a); else n_pass++;
            n_checks++; if (o_b !== 16'd0) $display("FAIL bub_bp out=%h exp 0000", o_b); else n_pass++;
         end
         beat = (c == 0 || c == 2 || c == 5 || c == 6);
         drive(beat, 8'h0F, 8'hFF);
         step();
      end
   endtask

   task automatic test_reset_mid_fold();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         n_checks++; if (ov_a !== (c == 9)) $display("FAIL midrst_outv c=%0d got %b exp %b", c, ov_a, (c == 9)); else n_pass++;
         if (c >= 3 && c < 9) begin
            n_checks++; if (o_a !== 16'd0) $display("FAIL midrst_hold c=%0d out=%0d exp 0", c, o_a); else n_pass++;
         end
         if (c == 9) begin
            n_checks++; if (o_a !== 16'd16) $display("FAIL midrst_out out=%0d exp 16", o_a); else n_pass++;
         end
         areset = (c == 2);
         if (c < 3) drive(1'b1, 8'hFF, 8'hFF);
         else if (c < 7) drive(1'b1, 8'hF0, 8'hFF);
         else drive(1'b0, 8'h00, 8'h00);
         step();
      end
      areset = 1'b0;
   endtask

   task automatic test_sf1_random();
      logic        ev [0:209];
      logic [15:0] eo [0:209];
      logic [15:0] last;
      logic [7:0]  a, w, x;
      logic        v;
      for (int i = 0; i < 210; i++) begin
         ev[i] = 1'b0;
         eo[i] = 16'd0;
      end
      last = 16'd0;
      do_reset();
      for (int c = 0; c < 204; c++) begin
         n_checks++; if (ov_c !== ev[c]) $display("FAIL sf1_outv c=%0d got %b exp %b", c, ov_c, ev[c]); else n_pass++;
         if (ev[c]) last = eo[c];
         n_checks++; if (o_c !== last) $display("FAIL sf1_out c=%0d got %0d exp %0d", c, o_c, last); else n_pass++;
         if (c < 200) begin
            v = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            w = 8'($urandom_range(0, 255));
         end else begin
            v = 1'b0; a = 8'h00; w = 8'h00;
         end
         x = ~(a ^ w);
         ev[c + 3] = v;
         eo[c + 3] = 16'($countones(x));
         drive(v, a, w);
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic pulse;
      do_reset();
      for (int c = 0; c < 17; c++) begin
         pulse = (c == 6 || c == 10 || c == 14);
         n_checks++; if (ov_a !== pulse) $display("FAIL b2b_outv c=%0d got %b exp %b", c, ov_a, pulse); else n_pass++;
         if (pulse) begin
            n_checks++; if (o_a !== 16'd16) $display("FAIL b2b_out c=%0d out=%0d exp 16", c, o_a); else n_pass++;
            n_checks++; if (o_b !== 16'd0) $display("FAIL b2b_bp c=%0d out=%h exp 0000", c, o_b); else n_pass++;
         end
         if (c < 12) drive(1'b1, (c % 2 == 0) ? 8'h55 : 8'hAA, 8'h55);
         else drive(1'b0, 8'h00, 8'h00);
         step();
      end
   endtask

   initial begin
      areset = 1'b1;
      drive(1'b0, 8'h00, 8'h00);
      step();
      test_reset();
      test_all_match();
      test_bipolar();
      test_bubbles();
      test_reset_mid_fold();
      test_sf1_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
